// File: rtl/cart_pkg.sv
// Shared types and constants for cartridge bank-switch detection.
// Used by cart_detect and by cart_sig_match, which is built only when
// CART_DETECT_SIG_EN is defined.
package cart_pkg;

  // Bank-switch codes consumed by the cartridge mapper.
  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  // Detector FSM states. The encoding is also visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Image sizes used by the size heuristic.
  localparam logic [16:0] SIZE_4K  = 17'd4096;
  localparam logic [16:0] SIZE_8K  = 17'd8192;
  localparam logic [16:0] SIZE_12K = 17'd12288;
  localparam logic [16:0] SIZE_16K = 17'd16384;
  localparam logic [16:0] SIZE_32K = 17'd32768;
  localparam logic [16:0] SIZE_MAX = 17'h1FFFF;

  // Signature bytes. 3F = {85,3F}; E0 = {8D,E0,1F}; FE = {20,00,D0,C6,C5}.
  localparam logic [7:0] SIG_3F_0 = 8'h85;
  localparam logic [7:0] SIG_3F_1 = 8'h3F;
  localparam logic [7:0] SIG_E0_0 = 8'h8D;
  localparam logic [7:0] SIG_E0_1 = 8'hE0;
  localparam logic [7:0] SIG_E0_2 = 8'h1F;
  localparam logic [7:0] SIG_FE_0 = 8'h20;
  localparam logic [7:0] SIG_FE_1 = 8'h00;
  localparam logic [7:0] SIG_FE_2 = 8'hD0;
  localparam logic [7:0] SIG_FE_3 = 8'hC6;
  localparam logic [7:0] SIG_FE_4 = 8'hC5;

  // SuperChip mode encodings; the unused value 3 behaves as auto.
  localparam logic [1:0] SC_AUTO    = 2'd0;
  localparam logic [1:0] SC_DISABLE = 2'd1;
  localparam logic [1:0] SC_ENABLE  = 2'd2;

  // Map a three-character extension to a forced bank-switch code.
  function automatic bs_t ext_to_bs(input logic [23:0] e);
    bs_t r;
    case (e)
      ".F8":   r = BS_F8;
      ".F6":   r = BS_F6;
      ".FE":   r = BS_FE;
      ".E0":   r = BS_E0;
      ".3F":   r = BS_3F;
      ".F4":   r = BS_F4;
      ".P2":   r = BS_P2;
      ".FA":   r = BS_FA;
      ".CV":   r = BS_CV;
      default: r = BS_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cart_sig_match.sv
// Signature scanner: a 5-byte shift register of written bytes, three
// pattern comparators and three 4-bit saturating hit counters.
// A write shifts the byte in; the comparison runs on the following cycle
// against the updated register, so every pattern byte is a real flop.
module cart_sig_match
  import cart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic [3:0] cnt_3f,
  output logic [3:0] cnt_e0,
  output logic [3:0] cnt_fe
);

  logic [4:0][7:0] sr_q, sr_d;     // sr_q[0] is the newest byte
  logic            pend_q, pend_d; // a byte was shifted in last cycle
  logic [3:0]      c3f_q, c3f_d;
  logic [3:0]      ce0_q, ce0_d;
  logic [3:0]      cfe_q, cfe_d;
  logic            hit_3f, hit_e0, hit_fe;

  // Pattern comparators on the registered window.
  always_comb begin
    hit_3f = (sr_q[1] == SIG_3F_0) && (sr_q[0] == SIG_3F_1);
    hit_e0 = (sr_q[2] == SIG_E0_0) && (sr_q[1] == SIG_E0_1) &&
             (sr_q[0] == SIG_E0_2);
    hit_fe = (sr_q[4] == SIG_FE_0) && (sr_q[3] == SIG_FE_1) &&
             (sr_q[2] == SIG_FE_2) && (sr_q[1] == SIG_FE_3) &&
             (sr_q[0] == SIG_FE_4);
  end

  // Shift and count; a clear from the top wipes everything.
  always_comb begin
    sr_d   = sr_q;
    pend_d = wr_en;
    c3f_d  = c3f_q;
    ce0_d  = ce0_q;
    cfe_d  = cfe_q;
    if (clear) begin
      sr_d   = '0;
      pend_d = 1'b0;
      c3f_d  = '0;
      ce0_d  = '0;
      cfe_d  = '0;
    end else begin
      if (wr_en) begin
        sr_d = {sr_q[3:0], din};
      end
      if (pend_q) begin
        if (hit_3f && (c3f_q != 4'hF)) c3f_d = c3f_q + 4'd1;
        if (hit_e0 && (ce0_q != 4'hF)) ce0_d = ce0_q + 4'd1;
        if (hit_fe && (cfe_q != 4'hF)) cfe_d = cfe_q + 4'd1;
      end
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      pend_q <= 1'b0;
      c3f_q  <= '0;
      ce0_q  <= '0;
      cfe_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      pend_q <= pend_d;
      c3f_q  <= c3f_d;
      ce0_q  <= ce0_d;
      cfe_q  <= cfe_d;
    end
  end

  assign cnt_3f = c3f_q;
  assign cnt_e0 = ce0_q;
  assign cnt_fe = cfe_q;

endmodule

// File: rtl/cart_detect.sv
// Cartridge bank-switch detector. Watches an image download, tracks its
// size and whether the first 256 bytes are uniform, then picks a
// bank-switch code from the extension, the size and (optionally) code
// signatures. Define CART_DETECT_SIG_EN to build the signature scanner.
module cart_detect
  import cart_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [23:0] ext,
  input  logic [1:0]  sc_mode,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        detect_done,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  logic        dl_q;
  logic        dl_rise, dl_fall;
  logic [16:0] rom_size_q, rom_size_d;
  bs_t         force_bs_q, force_bs_d;
  logic        sc_q, sc_d;
  logic [23:0] ext_q, ext_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  byte0_q, byte0_d;
  logic        seen0_q, seen0_d;
  logic        uniform_q, uniform_d;
  logic [25:0] addr_p1;
  logic [16:0] wr_size;
  bs_t         decide_bs;
  logic        decide_sc;
  logic        sig_wr;

  // Edge detection. dl_q follows the pin even in reset, so a download
  // already high at reset release is not seen as a new rising edge.
  assign dl_rise = ioctl_download && !dl_q;
  assign dl_fall = !ioctl_download && dl_q;

  // Only strobes inside an ongoing load are scanned.
  assign sig_wr = ioctl_wr && (state_q == ST_LOAD) && !dl_rise;

`ifdef CART_DETECT_SIG_EN
  logic [3:0] cnt_3f, cnt_e0, cnt_fe;

  cart_sig_match u_sig (
    .clk    (clk_sys),
    .reset  (reset),
    .clear  (dl_rise),
    .wr_en  (sig_wr),
    .din    (ioctl_dout),
    .cnt_3f (cnt_3f),
    .cnt_e0 (cnt_e0),
    .cnt_fe (cnt_fe)
  );
`endif

  // Size implied by the current strobe, saturated to 17 bits.
  always_comb begin
    addr_p1 = {1'b0, ioctl_addr} + 26'd1;
    wr_size = (addr_p1 > {9'd0, SIZE_MAX}) ? SIZE_MAX : addr_p1[16:0];
  end

  // Decision: extension first, then size, then signature overrides.
  always_comb begin
    case (rom_size_q)
      SIZE_8K:  decide_bs = BS_F8;
      SIZE_12K: decide_bs = BS_FA;
      SIZE_16K: decide_bs = BS_F6;
      SIZE_32K: decide_bs = BS_F4;
      default:  decide_bs = BS_NONE;
    endcase
`ifdef CART_DETECT_SIG_EN
    if ((rom_size_q == SIZE_8K) || (rom_size_q == SIZE_16K)) begin
      if (cnt_3f >= 4'd2) begin
        decide_bs = BS_3F;
      end else if ((rom_size_q == SIZE_8K) && (cnt_e0 != 4'd0)) begin
        decide_bs = BS_E0;
      end else if ((rom_size_q == SIZE_8K) && (cnt_fe != 4'd0)) begin
        decide_bs = BS_FE;
      end
    end
`endif
    if (ext_to_bs(ext_q) != BS_NONE) begin
      decide_bs = ext_to_bs(ext_q);
    end
    case (mode_q)
      SC_DISABLE: decide_sc = 1'b0;
      SC_ENABLE:  decide_sc = 1'b1;
      default:    decide_sc = uniform_q && seen0_q && (rom_size_q >= SIZE_8K);
    endcase
  end

  // Next-state and datapath updates; a rising download edge wins from
  // any state and restarts the load.
  always_comb begin
    state_d    = state_q;
    rom_size_d = rom_size_q;
    force_bs_d = force_bs_q;
    sc_d       = sc_q;
    ext_d      = ext_q;
    mode_d     = mode_q;
    byte0_d    = byte0_q;
    seen0_d    = seen0_q;
    uniform_d  = uniform_q;
    if (dl_rise) begin
      state_d    = ST_LOAD;
      rom_size_d = '0;
      force_bs_d = BS_NONE;
      sc_d       = 1'b0;
      ext_d      = ext;
      mode_d     = sc_mode;
      byte0_d    = '0;
      seen0_d    = 1'b0;
      uniform_d  = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ioctl_wr) begin
            if (wr_size > rom_size_q) rom_size_d = wr_size;
            if (ioctl_addr == 25'd0) begin
              byte0_d = ioctl_dout;
              seen0_d = 1'b1;
            end else if (ioctl_addr < 25'h100) begin
              if (!seen0_q || (ioctl_dout != byte0_q)) uniform_d = 1'b0;
            end
          end
          if (dl_fall) state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          force_bs_d = decide_bs;
          sc_d       = decide_sc;
          state_d    = ST_DONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Download edge register, free-running.
  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_size_q <= '0;
      force_bs_q <= BS_NONE;
      sc_q       <= 1'b0;
      ext_q      <= '0;
      mode_q     <= '0;
      byte0_q    <= '0;
      seen0_q    <= 1'b0;
      uniform_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_size_q <= rom_size_d;
      force_bs_q <= force_bs_d;
      sc_q       <= sc_d;
      ext_q      <= ext_d;
      mode_q     <= mode_d;
      byte0_q    <= byte0_d;
      seen0_q    <= seen0_d;
      uniform_q  <= uniform_d;
    end
  end

  assign force_bs    = force_bs_q;
  assign sc          = sc_q;
  assign rom_size    = rom_size_q;
  assign detect_done = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cart_detect.sv
// Directed bench for cart_detect: a table of whole-image downloads plus
// hand-written sequences for reset, restart and saturation corners.
// Expectations follow CART_DETECT_SIG_EN when it is defined.
module tb_cart_detect;
  import cart_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [23:0] ext = "BIN";
  logic [1:0]  sc_mode = 2'd0;
  logic [3:0]  force_bs;
  logic        sc;
  logic [16:0] rom_size;
  logic        detect_done;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];  // {force_bs, sc, rom_size}

`ifdef CART_DETECT_SIG_EN
  localparam logic [3:0] X_E0_8K  = 4'd4;
  localparam logic [3:0] X_FE_8K  = 4'd3;
  localparam logic [3:0] X_3F_16K = 4'd5;
`else
  localparam logic [3:0] X_E0_8K  = 4'd1;
  localparam logic [3:0] X_FE_8K  = 4'd1;
  localparam logic [3:0] X_3F_16K = 4'd2;
`endif

  localparam int SG_NONE = 0;
  localparam int SG_3F   = 1;
  localparam int SG_E0   = 2;
  localparam int SG_FE   = 3;

  typedef struct {
    int          size;
    logic [23:0] e;
    logic [1:0]  m;
    logic [7:0]  fill;
    bit          brk;
    int          sig;
    int          nsig;
    logic [3:0]  exp_bs;
    bit          exp_sc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  cart_detect dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ext            (ext),
    .sc_mode        (sc_mode),
    .force_bs       (force_bs),
    .sc             (sc),
    .rom_size       (rom_size),
    .detect_done    (detect_done),
    .dbg_state      (dbg_state)
  );

  // Clock.
  initial forever #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a[24:0];
    ioctl_dout = d;
    step();
  endtask

  task automatic dl_start(input logic [23:0] e, input logic [1:0] m);
    ext            = e;
    sc_mode        = m;
    ioctl_download = 1'b1;
    step();
  endtask

  // Sparse image: first 256 bytes, signature copies at 1024, last byte.
  task automatic dl_body(input int size, input logic [7:0] fill, input bit brk,
                         input int sig, input int nsig);
    int a;
    int n;
    n = (size < 256) ? size : 256;
    for (int i = 0; i < n; i++) wr_byte(i, (brk && i == 128) ? 8'h5A : fill);
    a = 1024;
    if (size > 2048) begin
      for (int k = 0; k < nsig; k++) begin
        case (sig)
          SG_3F: begin
            wr_byte(a, 8'h85); wr_byte(a + 1, 8'h3F); a += 2;
          end
          SG_E0: begin
            wr_byte(a, 8'h8D); wr_byte(a + 1, 8'hE0); wr_byte(a + 2, 8'h1F); a += 3;
          end
          SG_FE: begin
            wr_byte(a, 8'h20); wr_byte(a + 1, 8'h00); wr_byte(a + 2, 8'hD0);
            wr_byte(a + 3, 8'hC6); wr_byte(a + 4, 8'hC5); a += 5;
          end
          default: begin
          end
        endcase
        wr_byte(a, 8'h00);
        a += 1;
      end
    end
    wr_byte(size - 1, 8'h00);
  endtask

  // Drop download, check the two-cycle decision latency and the outputs.
  task automatic dl_finish(input string name);
    logic [21:0] ex;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step();
    chk({name, " done_early"}, detect_done, 0);
    step();
    chk({name, " done"}, detect_done, 1);
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard_empty"}, 1, 0);
    end else begin
      ex = exp_q.pop_front();
      chk({name, " force_bs"}, force_bs, ex[21:18]);
      chk({name, " sc"}, sc, ex[17]);
      chk({name, " rom_size"}, rom_size, ex[16:0]);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    dl_start(v.e, v.m);
    dl_body(v.size, v.fill, v.brk, v.sig, v.nsig);
    exp_q.push_back({v.exp_bs, v.exp_sc, v.size[16:0]});
    dl_finish(name);
  endtask

  initial begin
    vecs[0]  = '{4096,  "BIN", 2'd0, 8'h00, 1'b0, SG_NONE, 0, 4'd0, 1'b0};
    vecs[1]  = '{8192,  "BIN", 2'd0, 8'h11, 1'b1, SG_E0,   1, X_E0_8K, 1'b0};
    vecs[2]  = '{8192,  ".F6", 2'd0, 8'h22, 1'b0, SG_3F,   3, 4'd2, 1'b1};
    vecs[3]  = '{16384, "BIN", 2'd0, 8'hFF, 1'b0, SG_NONE, 0, 4'd2, 1'b1};
    vecs[4]  = '{16384, "BIN", 2'd1, 8'hFF, 1'b0, SG_NONE, 0, 4'd2, 1'b0};
    vecs[5]  = '{12288, "BIN", 2'd2, 8'h33, 1'b1, SG_NONE, 0, 4'd8, 1'b1};
    vecs[6]  = '{32768, "BIN", 2'd0, 8'h44, 1'b0, SG_NONE, 0, 4'd6, 1'b1};
    vecs[7]  = '{8192,  "BIN", 2'd0, 8'h55, 1'b0, SG_FE,   1, X_FE_8K, 1'b1};
    vecs[8]  = '{16384, "BIN", 2'd0, 8'h66, 1'b1, SG_3F,   2, X_3F_16K, 1'b0};
    vecs[9]  = '{16384, "BIN", 2'd0, 8'h77, 1'b0, SG_E0,   1, 4'd2, 1'b1};
    vecs[10] = '{8192,  "BIN", 2'd0, 8'h88, 1'b1, SG_3F,   1, 4'd1, 1'b0};
    vecs[11] = '{10000, "BIN", 2'd0, 8'h99, 1'b0, SG_NONE, 0, 4'd0, 1'b1};
    vecs[12] = '{8192,  ".CV", 2'd2, 8'hAA, 1'b1, SG_NONE, 0, 4'd9, 1'b1};
    vecs[13] = '{16384, ".P2", 2'd1, 8'hBB, 1'b0, SG_NONE, 0, 4'd7, 1'b0};
    vecs[14] = '{2048,  "BIN", 2'd0, 8'hCC, 1'b0, SG_NONE, 0, 4'd0, 1'b0};
    vecs[15] = '{4096,  ".E0", 2'd0, 8'hDD, 1'b0, SG_NONE, 0, 4'd4, 1'b0};
    vecs[16] = '{32768, ".F8", 2'd0, 8'hEE, 1'b0, SG_NONE, 0, 4'd1, 1'b1};
    vecs[17] = '{8192,  ".FE", 2'd1, 8'h01, 1'b0, SG_NONE, 0, 4'd3, 1'b0};
    vecs[18] = '{4096,  ".3F", 2'd2, 8'h02, 1'b0, SG_NONE, 0, 4'd5, 1'b1};
    vecs[19] = '{16384, ".F4", 2'd0, 8'h03, 1'b0, SG_NONE, 0, 4'd6, 1'b1};
    vecs[20] = '{12288, ".FA", 2'd0, 8'h04, 1'b0, SG_NONE, 0, 4'd8, 1'b1};

    // Reset with download already high: release must not start a load.
    ioctl_download = 1'b1;
    repeat (3) step();
    chk("rst force_bs", force_bs, 0);
    chk("rst sc", sc, 0);
    chk("rst rom_size", rom_size, 0);
    chk("rst done", detect_done, 0);
    chk("rst state", dbg_state, ST_IDLE);
    reset = 1'b0;
    step();
    wr_byte(100, 8'h12);
    ioctl_wr = 1'b0;
    step();
    chk("high_at_release state", dbg_state, ST_IDLE);
    chk("high_at_release rom_size", rom_size, 0);
    ioctl_download = 1'b0;
    step();

    // Table of complete downloads.
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // DONE holds, and strobes outside a load are ignored.
    repeat (5) step();
    chk("hold done", detect_done, 1);
    chk("hold force_bs", force_bs, 8);
    wr_byte(25'h1FFFF0, 8'h00);
    ioctl_wr = 1'b0;
    step();
    chk("wr_outside rom_size", rom_size, 12288);

    // Second download directly after DONE.
    dl_start("BIN", 2'd0);
    chk("redl done_drop", detect_done, 0);
    chk("redl force_bs_clr", force_bs, 0);
    chk("redl rom_size_clr", rom_size, 0);
    dl_body(32768, 8'h10, 1'b0, SG_NONE, 0);
    exp_q.push_back({4'd6, 1'b1, 17'd32768});
    dl_finish("redl");

    // Rising edge while in DECIDE restarts the load.
    dl_start(".FA", 2'd0);
    dl_body(4096, 8'h20, 1'b0, SG_NONE, 0);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step();
    chk("decide_rise in_decide", dbg_state, ST_DECIDE);
    ext            = "BIN";
    ioctl_download = 1'b1;
    step();
    chk("decide_rise to_load", dbg_state, ST_LOAD);
    step();
    chk("decide_rise done", detect_done, 0);
    chk("decide_rise force_bs", force_bs, 0);
    dl_body(16384, 8'h12, 1'b0, SG_NONE, 0);
    exp_q.push_back({4'd2, 1'b1, 17'd16384});
    dl_finish("decide_rise");

    // Reset in the middle of an 8K load abandons it.
    dl_start("BIN", 2'd0);
    for (int a = 0; a < 1000; a++) wr_byte(a, 8'h00);
    ioctl_wr = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 1000; a < 1500; a++) wr_byte(a, 8'h00);
    ioctl_wr = 1'b0;
    chk("mid_rst rom_size", rom_size, 0);
    chk("mid_rst state", dbg_state, ST_IDLE);
    ioctl_download = 1'b0;
    repeat (3) step();
    chk("mid_rst done", detect_done, 0);
    chk("mid_rst force_bs", force_bs, 0);
    chk("mid_rst sc", sc, 0);
    dl_start("BIN", 2'd0);
    dl_body(8192, 8'h00, 1'b0, SG_NONE, 0);
    exp_q.push_back({4'd1, 1'b1, 17'd8192});
    dl_finish("after_rst");

    // Address beyond 17 bits saturates; a lower address keeps the max.
    dl_start("BIN", 2'd0);
    wr_byte(32'h01FF_FFFF, 8'h00);
    chk("sat rom_size", rom_size, 17'h1FFFF);
    wr_byte(5, 8'h00);
    chk("sat keep_max", rom_size, 17'h1FFFF);
    exp_q.push_back({4'd0, 1'b0, 17'h1FFFF});
    dl_finish("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cart_detect.md
CART_DETECT -- requirements
Module: cart_detect

Interface
REQ-001 SHALL have: clk_sys  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ioctl_download  in  1  high while the cartridge image is being downloaded.
REQ-004 SHALL have: ioctl_wr  in  1  one-cycle strobe, one image byte per strobe.
REQ-005 SHALL have: ioctl_addr  in  25  byte address of the current strobe.
REQ-006 SHALL have: ioctl_dout  in  8  byte data of the current strobe.
REQ-007 SHALL have: ext  in  24  three-character file extension (ASCII), e.g. ".F8".
REQ-008 SHALL have: sc_mode  in  2  SuperChip mode: 0 = auto, 1 = disable, 2 = enable.
REQ-009 SHALL have: force_bs  out  4  bank-switch code, consumed by the cartridge mapper.
REQ-010 SHALL have: sc  out  1  SuperChip RAM enable.
REQ-011 SHALL have: rom_size  out  17  number of bytes written, saturating at 17'h1FFFF.
REQ-012 SHALL have: detect_done  out  1  high while force_bs and sc hold a valid decision.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> DECIDE -> DONE.
REQ-014 SHALL enter LOAD on a rising edge of ioctl_download, from any state (detected with a registered copy of ioctl_download).
REQ-015 On entering LOAD, SHALL clear all counters and outputs, and latch ext and sc_mode.
REQ-016 In LOAD, each ioctl_wr SHALL set rom_size to max(rom_size, ioctl_addr+1), saturating at 17'h1FFFF.
REQ-017 In LOAD, SHALL track sc_uniform = 1 iff bytes at addresses 0x000-0x0FF are all equal to the byte at address 0x000.
REQ-018 On the falling edge of ioctl_download, SHALL go LOAD -> DECIDE; DECIDE lasts exactly 1 cycle, then DONE.
REQ-019 Extension priority: a latched ext of .F8/.F6/.FE/.E0/.3F/.F4/.P2/.FA/.CV SHALL map to codes 1..9 and override all heuristics.
REQ-020 Size heuristic, otherwise:
- <= 4096: code 0.
- 8192: code 1, unless overridden by a signature.
- 12288: code 8.
- 16384: code 2.
- 32768: code 6.
- any other size: code 0.
REQ-021 Signature override SHALL apply only for 8192 or 16384 byte images:
- 3F hits >= 2: code 5 (highest priority).
- else E0 hits >= 1 and 8K: code 4.
- else FE hits >= 1 and 8K: code 3.
REQ-022 sc SHALL resolve as: sc_mode 1 -> 0; sc_mode 2 -> 1; sc_mode 0 -> sc_uniform AND rom_size >= 8192.
REQ-023 force_bs, sc and rom_size SHALL be registered, and SHALL update only in DECIDE; rom_size also updates during LOAD.
REQ-024 detect_done SHALL be 1 only in DONE.
REQ-025 DONE SHALL hold outputs until the next download rising edge.
REQ-026 ioctl_wr outside LOAD SHALL be ignored.
REQ-027 A falling and a rising download edge cannot coincide (single-bit signal); a rising edge in DECIDE SHALL still take priority and go to LOAD.
REQ-028 Signature hit counters SHALL be 4-bit and saturate at 15.

Reset
REQ-029 reset SHALL force IDLE with force_bs=0, sc=0, rom_size=0, detect_done=0, and all counters and shift registers cleared.
REQ-030 reset during LOAD SHALL abandon the download: stay IDLE, ignore remaining strobes until the next rising edge of ioctl_download after reset deasserts.
REQ-031 ioctl_download already high at reset release SHALL NOT count as a rising edge.

Configuration
REQ-032 Macro CART_DETECT_SIG_EN defined: signature scanning is present.
- 5-byte shift register of written bytes.
- Patterns: 3F = {85,3F}; E0 = {8D,E0,1F}; FE = {20,00,D0,C6,C5}.
- Hits counted on each ioctl_wr whose newest bytes match.
REQ-033 Macro undefined: no shift register or counters are synthesized; REQ-021 never applies; decision uses extension and size only.

Structure
REQ-034 Shared package cart_pkg SHALL hold:
- bs_t enum: BS_NONE=0, BS_F8, BS_F6, BS_FE, BS_E0, BS_3F, BS_F4, BS_P2, BS_FA, BS_CV=9.
- Size constants.
- Signature byte constants.
- sc_mode encodings.
REQ-035 Sub-module cart_sig_match (shift register, three comparators, saturating counters) SHALL be instantiated only under CART_DETECT_SIG_EN.

Verification
REQ-036 Image of 4096 bytes, ext ".BIN", sc_mode 0 -> force_bs=0, sc=0, rom_size=4096, detect_done high 2 cycles after download falls.
REQ-037 Image of 8192 bytes, ext ".BIN", containing {8D,E0,1F} once -> force_bs=4 (macro defined) / 1 (macro undefined).
REQ-038 Image of 8192 bytes, ext ".F6", containing {85,3F} x3 -> force_bs=2 (extension wins).
REQ-039 Image of 16384 bytes, first 256 bytes all 0xFF, sc_mode 0 -> force_bs=2, sc=1; same image with sc_mode 1 -> sc=0.
REQ-040 reset asserted after 1000 bytes of an 8K load, then release -> outputs 0, detect_done 0 until a fresh download completes.
REQ-041 Second download of a 32768-byte image directly after DONE -> detect_done drops on the rising edge, then force_bs=6, rom_size=32768.
